// File: rtl/inst_encoder.sv
// Field-level request to RV32IM instruction word encoder with a DEPTH-entry output FIFO.
// The LI pseudo-op is split into LUI + ADDI; the ADDI half is parked in LI_LO until there is room.
module inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_kind,
    input  logic [2:0]               req_funct3,
    input  logic                     req_f7b5,
    input  logic                     req_mext,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    input  logic [31:0]              req_imm,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_valid,
    output logic [1:0]               err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] K_OP     = 4'd0;
    localparam logic [3:0] K_OP_IMM = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_LUI    = 4'd7;
    localparam logic [3:0] K_AUIPC  = 4'd8;
    localparam logic [3:0] K_LI     = 4'd9;
    localparam logic [3:0] K_HALT   = 4'd10;

    localparam logic [1:0] ERR_KIND = 2'd1;
    localparam logic [1:0] ERR_IMM  = 2'd2;

    typedef enum logic {IDLE, LI_LO} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pend_q, pend_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     sh11, sh12, sh20;
    logic            fits_i, fits_b, fits_j;
    logic [19:0]     li_hi;
    logic [31:0]     enc_word, enc_lo;
    logic            enc_two;
    logic [1:0]      enc_code;
    logic            accept, push, pop;
    logic [31:0]     push_data;

    // Arithmetic shifts collapse to all-zeros/all-ones exactly when the value fits the signed field.
    assign sh11   = 32'($signed(req_imm) >>> 11);
    assign sh12   = 32'($signed(req_imm) >>> 12);
    assign sh20   = 32'($signed(req_imm) >>> 20);
    assign fits_i = (sh11 == '0) || (sh11 == '1);
    assign fits_b = !req_imm[0] && ((sh12 == '0) || (sh12 == '1));
    assign fits_j = !req_imm[0] && ((sh20 == '0) || (sh20 == '1));
    // Rounding the upper part compensates for ADDI sign-extending its 12-bit immediate.
    assign li_hi  = req_imm[31:12] + 20'(req_imm[11]);

    always_comb begin
        enc_word = '0;
        enc_lo   = '0;
        enc_two  = 1'b0;
        enc_code = 2'd0;
        case (req_kind)
            K_OP: begin
                enc_word = {req_mext ? 7'b0000001 : {1'b0, req_f7b5, 5'b00000},
                            req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
            end
            K_OP_IMM: begin
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
                    if (req_imm[31:5] != '0) enc_code = ERR_IMM;
                    enc_word = {1'b0, req_f7b5, 5'b00000, req_imm[4:0],
                                req_rs1, req_funct3, req_rd, OPC_OP_IMM};
                end else begin
                    if (!fits_i) enc_code = ERR_IMM;
                    enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OP_IMM};
                end
            end
            K_LOAD, K_JALR: begin
                if (!fits_i) enc_code = ERR_IMM;
                enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd,
                            (req_kind == K_LOAD) ? OPC_LOAD : OPC_JALR};
            end
            K_STORE: begin
                if (!fits_i) enc_code = ERR_IMM;
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
            end
            K_BRANCH: begin
                if (!fits_b) enc_code = ERR_IMM;
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], OPC_BRANCH};
            end
            K_JAL: begin
                if (!fits_j) enc_code = ERR_IMM;
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OPC_JAL};
            end
            K_LUI, K_AUIPC: begin
                if (req_imm[11:0] != '0) enc_code = ERR_IMM;
                enc_word = {req_imm[31:12], req_rd, (req_kind == K_LUI) ? OPC_LUI : OPC_AUIPC};
            end
            K_LI: begin
                if (fits_i) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OP_IMM};
                end else begin
                    enc_word = {li_hi, req_rd, OPC_LUI};
                    enc_two  = (req_imm[11:0] != '0);
                end
                enc_lo = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OP_IMM};
            end
            K_HALT: enc_word = 32'hFFFF_FFFF;
            default: enc_code = ERR_KIND;
        endcase
    end

    assign req_ready  = nRST && (state_q == IDLE) && (count_q < FULL);
    assign accept     = req_valid && req_ready;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        push        = 1'b0;
        push_data   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (enc_code != 2'd0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = enc_code;
                    end else begin
                        push      = 1'b1;
                        push_data = enc_word;
                        if (enc_two) begin
                            state_d = LI_LO;
                            pend_d  = enc_lo;
                        end
                    end
                end
            end
            LI_LO: begin
                if (count_q < FULL) begin
                    push      = 1'b1;
                    push_data = pend_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign inst      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule
